// File: rtl/switch_box_param_if.sv
// rtl/switch_box_param_if.sv - track, PE and configuration signals of the switch box
interface switch_box_param_if #(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 1
);
  logic [4*NUM_TRACKS*WIDTH-1:0] in_wires;
  logic [4*NUM_TRACKS*WIDTH-1:0] out_wires;
  logic [WIDTH-1:0]              pe_output;
  logic [31:0]                   config_data;
  logic [7:0]                    config_addr;
  logic                          config_en;
  logic                          config_commit;
  logic [31:0]                   config_rdata;
  logic                          commit_done;
  logic                          config_err;

  modport master (
    output in_wires, pe_output, config_data, config_addr, config_en, config_commit,
    input  out_wires, config_rdata, commit_done, config_err
  );

  modport slave (
    input  in_wires, pe_output, config_data, config_addr, config_en, config_commit,
    output out_wires, config_rdata, commit_done, config_err
  );
endinterface

// File: rtl/switch_box_param.sv
// rtl/switch_box_param.sv - parameterised routing switch box with shadow/active configuration
module switch_box_param #(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 1
) (
  input  logic               clk,
  input  logic               reset,
  switch_box_param_if.slave  bus
);
  localparam int         N_OUT     = 4 * NUM_TRACKS;
  localparam int         NUM_WORDS = (N_OUT + 7) / 8;
  localparam int         AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [7:0] LAST_ADDR = 8'(NUM_WORDS - 1);

  logic [31:0]   shadow [NUM_WORDS];
  logic [31:0]   active [NUM_WORDS];
  logic [31:0]   rdata_q;
  logic          commit_done_q;
  logic          err_q;
  logic          addr_ok;
  logic [AW-1:0] widx;
  logic          unused_tail;

  assign addr_ok     = (bus.config_addr <= LAST_ADDR);
  assign widx        = bus.config_addr[AW-1:0];
  assign unused_tail = ^active[NUM_WORDS-1];

  // Nonblocking copy of shadow into active means a same-edge write is seen
  // only by the shadow, and readback returns the pre-write word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      rdata_q       <= '0;
      commit_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (bus.config_en) begin
        if (addr_ok) begin
          shadow[widx] <= bus.config_data;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (bus.config_commit) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          active[i] <= shadow[i];
        end
      end
      commit_done_q <= bus.config_commit;
      rdata_q       <= addr_ok ? shadow[widx] : 32'h0;
    end
  end

  assign bus.config_rdata = rdata_q;
  assign bus.commit_done  = commit_done_q;
  assign bus.config_err   = err_q;

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
      localparam int K = s * NUM_TRACKS + t;

      logic [3:0]       field;
      logic [WIDTH-1:0] src1;
      logic [WIDTH-1:0] src2;
      logic [WIDTH-1:0] src3;
      logic [WIDTH-1:0] route;
      logic [WIDTH-1:0] pipe_q;
      logic             unused_reserved;

      assign field           = active[K/8][4*(K%8) +: 4];
      assign unused_reserved = field[3];
      assign src1 = bus.in_wires[(((s + 1) % 4) * NUM_TRACKS + t) * WIDTH +: WIDTH];
      assign src2 = bus.in_wires[(((s + 2) % 4) * NUM_TRACKS + t) * WIDTH +: WIDTH];
      assign src3 = bus.in_wires[(((s + 3) % 4) * NUM_TRACKS + t) * WIDTH +: WIDTH];

      always_comb begin
        route = bus.pe_output;
        case (field[1:0])
          2'd0:    route = src1;
          2'd1:    route = src2;
          2'd2:    route = src3;
          default: route = bus.pe_output;
        endcase
      end

      // Captures every edge regardless of reg_mode so switching modes never exposes stale data.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= route;
        end
      end

      assign bus.out_wires[K*WIDTH +: WIDTH] = field[2] ? pipe_q : route;
    end
  end
endmodule

// File: doc/switch_box_param.md
SWITCH_BOX_PARAM -- requirements
Module: switch_box_param

Interface
- REQ-001: Parameter NUM_TRACKS, default 4; tracks per side, legal range 1..16.
- REQ-002: Parameter WIDTH, default 1; bits per track, legal range 1..32.
- REQ-003: Derived N_OUT = 4*NUM_TRACKS output fields; NUM_WORDS = ceil(N_OUT/8) config words.
- REQ-004: clk  input  1  single clock for the block; all state updates on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: in_wires  input  4*NUM_TRACKS*WIDTH  track inputs; side s, track t at bits ((s*NUM_TRACKS+t)*WIDTH) +: WIDTH.
- REQ-007: pe_output  input  WIDTH  processing-element result, routable to any output.
- REQ-008: out_wires  output  4*NUM_TRACKS*WIDTH  track outputs, same packing as in_wires.
- REQ-009: config_data  input  32  configuration write word.
- REQ-010: config_addr  input  8  configuration word index.
- REQ-011: config_en  input  1  write strobe for the shadow configuration.
- REQ-012: config_commit  input  1  copies the shadow configuration to the active configuration.
- REQ-013: config_rdata  output  32  shadow word readback.
- REQ-014: commit_done  output  1  one-cycle pulse confirming a commit.
- REQ-015: config_err  output  1  sticky flag for out-of-range writes.

Function
- REQ-016: Output field k = s*NUM_TRACKS+t occupies word k/8, bits 4*(k%8) +: 4: [1:0] sel, [2] reg_mode, [3] reserved (stored, no effect).
- REQ-017: Combinational route for output (s,t): sel 0/1/2 selects in_wires side (s+1)%4, (s+2)%4 or (s+3)%4, track t; sel 3 selects pe_output.
- REQ-018: Each output has a WIDTH-bit pipeline flop that captures its combinational route value, computed from the active config, on every clock edge.
- REQ-019: Output (s,t) drives the pipeline flop when active reg_mode=1, and the combinational route otherwise (zero-latency path).
- REQ-020: A write with config_en=1 and config_addr<NUM_WORDS stores config_data into shadow word config_addr at the clock edge.
- REQ-021: Shadow contents never affect routing until committed.
- REQ-022: A write with config_en=1 and config_addr>=NUM_WORDS is discarded and sets config_err=1; config_err stays set until reset.
- REQ-023: config_commit=1 copies all shadow words into the active config at the clock edge; commit_done=1 for exactly the following cycle.
- REQ-024: Back-to-back commits give back-to-back commit_done pulses.
- REQ-025: Write and commit in the same cycle: the commit copies the pre-write shadow; the new word lands in shadow only.
- REQ-026: On a commit edge, pipeline flops capture their route values using the pre-commit active config.
- REQ-027: config_rdata is registered: it equals shadow word config_addr as sampled one cycle earlier, or 0 if that address was out of range.
- REQ-028: Simultaneous write and read of the same address returns the old shadow word on the following cycle.
- REQ-029: Bits of the last word beyond field N_OUT-1 are stored and read back, but have no routing effect.

Reset
- REQ-030: While reset=0, all shadow words, active words, pipeline flops, config_rdata, commit_done and config_err are 0, asynchronously.
- REQ-031: After reset, every output combinationally routes from side (s+1)%4, same track (sel 0, reg_mode 0).
- REQ-032: Reset asserted mid-operation aborts any same-edge write or commit; the first edge after release is a normal cycle.

Verification
- REQ-033: Reset defaults (NUM_TRACKS=4, WIDTH=1): release reset, in_wires=16'h0010 -> out_wires=16'h0001 (side1 track0 -> side0 track0) with no register latency; config_err=0.
- REQ-034: Shadow isolation and commit: write word0=32'h3, no commit -> output (0,0) unchanged; assert config_commit -> commit_done=1 next cycle, output (0,0) equals pe_output.
- REQ-035: Registered mode: commit field0=4'h7, toggle pe_output 0->1 -> output (0,0) rises one cycle after pe_output.
- REQ-036: Same-cycle write and commit: write word1=32'hFFFF_FFFF with commit -> active word1 stays 0; a second commit applies it; config_rdata for addr1 reads 32'hFFFF_FFFF.
- REQ-037: Error handling: with NUM_WORDS=2, write config_addr=5 -> config_err=1, shadow unchanged, config_rdata at addr 5 = 0; config_err clears only on reset.
- REQ-038: Asynchronous reset: assert reset mid-commit with NUM_TRACKS=8, WIDTH=4 -> all state and outputs return immediately to REQ-030/031 values.
